// File: rtl/stack_scoreboard_register_file.sv
// General-purpose register file: register 0 is a push/pop stack pointer,
// registers 1..N-1 are general, with a per-register pending-write scoreboard.
module stack_scoreboard_register_file #(
  parameter int unsigned ADDRESS_WIDTH = 2,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] STACK_BASE = '1,
  parameter int unsigned PROCESSOR_ID  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     general_register_write_enable,
  input  logic [ADDRESS_WIDTH-1:0] address_3,
  input  logic [DATA_WIDTH-1:0]    general_register_write_data,
  input  logic                     stack_write_enable,
  input  logic [DATA_WIDTH-1:0]    stack_register_write_data,
  input  logic [1:0]               stack_operation,
  input  logic                     issue_enable,
  input  logic [ADDRESS_WIDTH-1:0] issue_destination,
  input  logic [ADDRESS_WIDTH-1:0] address_1,
  input  logic [ADDRESS_WIDTH-1:0] address_2,
  output logic [DATA_WIDTH-1:0]    read_data_1,
  output logic [DATA_WIDTH-1:0]    read_data_2,
  output logic                     pending_1,
  output logic                     pending_2,
  output logic [DATA_WIDTH-1:0]    stack_pointer,
  output logic                     stack_overflow,
  output logic                     stack_underflow,
  output logic [DATA_WIDTH-1:0]    id
);

  localparam int unsigned REG_COUNT = 2 ** ADDRESS_WIDTH;
  localparam logic [1:0]  OP_PUSH   = 2'b01;
  localparam logic [1:0]  OP_POP    = 2'b10;

  // Entry 0 is never written; address-0 reads are redirected to the stack pointer.
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [REG_COUNT-1:0]  pending;
  logic                  write_valid;
  logic                  issue_valid;

  assign write_valid = general_register_write_enable && (address_3 != '0);
  assign issue_valid = issue_enable && (issue_destination != '0);
  assign id          = DATA_WIDTH'(PROCESSOR_ID);

  // General register storage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (write_valid) begin
      regs[address_3] <= general_register_write_data;
    end
  end

  // Stack pointer with sticky overflow/underflow; a direct load masks push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      stack_pointer   <= STACK_BASE;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (stack_write_enable) begin
      stack_pointer <= stack_register_write_data;
    end else if (stack_operation == OP_PUSH) begin
      if (stack_pointer == '0) begin
        stack_overflow <= 1'b1;
      end else begin
        stack_pointer <= stack_pointer - DATA_WIDTH'(1);
      end
    end else if (stack_operation == OP_POP) begin
      if (stack_pointer == STACK_BASE) begin
        stack_underflow <= 1'b1;
      end else begin
        stack_pointer <= stack_pointer + DATA_WIDTH'(1);
      end
    end
  end

  // Scoreboard: issue sets, write-back clears, set wins on collision
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending[0] <= 1'b0;
      for (int unsigned i = 1; i < REG_COUNT; i++) begin
        if (issue_valid && (issue_destination == ADDRESS_WIDTH'(i))) begin
          pending[i] <= 1'b1;
        end else if (write_valid && (address_3 == ADDRESS_WIDTH'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Read ports with same-cycle write-back forwarding
  always_comb begin
    read_data_1 = regs[address_1];
    read_data_2 = regs[address_2];
    if (address_1 == '0) begin
      read_data_1 = stack_pointer;
    end else if (write_valid && (address_3 == address_1)) begin
      read_data_1 = general_register_write_data;
    end
    if (address_2 == '0) begin
      read_data_2 = stack_pointer;
    end else if (write_valid && (address_3 == address_2)) begin
      read_data_2 = general_register_write_data;
    end
  end

  // A write landing this cycle resolves the hazard as seen by decode
  always_comb begin
    pending_1 = pending[address_1] &&
                !(general_register_write_enable && (address_3 == address_1));
    pending_2 = pending[address_2] &&
                !(general_register_write_enable && (address_3 == address_2));
  end

endmodule

// File: tb/tb_stack_scoreboard_register_file.sv
// Directed plus randomized bench for stack_scoreboard_register_file against
// an array-based reference model of the register file, stack and scoreboard.
module tb_stack_scoreboard_register_file;

  localparam int unsigned AW   = 2;
  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 4;
  localparam logic [7:0]  BASE = 8'hFF;
  localparam int unsigned PID  = 0;

  logic          clk;
  logic          reset;
  logic          we;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd;
  logic          swe;
  logic [DW-1:0] swd;
  logic [1:0]    op;
  logic          iss;
  logic [AW-1:0] idst;
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          p1;
  logic          p2;
  logic [DW-1:0] sp;
  logic          ovf;
  logic          udf;
  logic [DW-1:0] id;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_regs [NREG];
  bit         m_pend [NREG];
  logic [7:0] m_sp;
  bit         m_ovf;
  bit         m_udf;

  stack_scoreboard_register_file #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .STACK_BASE(BASE), .PROCESSOR_ID(PID)
  ) dut (
    .clk(clk), .reset(reset),
    .general_register_write_enable(we), .address_3(a3),
    .general_register_write_data(wd),
    .stack_write_enable(swe), .stack_register_write_data(swd),
    .stack_operation(op), .issue_enable(iss), .issue_destination(idst),
    .address_1(a1), .address_2(a2),
    .read_data_1(rd1), .read_data_2(rd2), .pending_1(p1), .pending_2(p2),
    .stack_pointer(sp), .stack_overflow(ovf), .stack_underflow(udf), .id(id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_read(input int a);
    if (a == 0) return m_sp;
    if (we && int'(a3) == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic exp_pend(input int a);
    return m_pend[a] && !(we && int'(a3) == a);
  endfunction

  task automatic check_all();
    chk("read_data_1", 32'(rd1), 32'(exp_read(int'(a1))));
    chk("read_data_2", 32'(rd2), 32'(exp_read(int'(a2))));
    chk("pending_1", 32'(p1), 32'(exp_pend(int'(a1))));
    chk("pending_2", 32'(p2), 32'(exp_pend(int'(a2))));
    chk("stack_pointer", 32'(sp), 32'(m_sp));
    chk("stack_overflow", 32'(ovf), 32'(m_ovf));
    chk("stack_underflow", 32'(udf), 32'(m_udf));
    chk("id", 32'(id), 32'(PID));
  endtask

  task automatic model_update();
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = 8'h00;
        m_pend[i] = 1'b0;
      end
      m_sp  = BASE;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (we && a3 != 0) begin
        m_regs[a3] = wd;
        m_pend[a3] = 1'b0;
      end
      if (iss && idst != 0) m_pend[idst] = 1'b1;
      if (swe) m_sp = swd;
      else if (op == 2'b01) begin
        if (m_sp == 8'h00) m_ovf = 1'b1;
        else m_sp = m_sp - 8'd1;
      end else if (op == 2'b10) begin
        if (m_sp == BASE) m_udf = 1'b1;
        else m_sp = m_sp + 8'd1;
      end
    end
  endtask

  task automatic idle();
    reset = 0; we = 0; a3 = 0; wd = 0; swe = 0; swd = 0; op = 0;
    iss = 0; idst = 0;
  endtask

  task automatic probe();
    #1;
    check_all();
  endtask

  // Check combinational outputs, clock once, advance the model
  task automatic cycle();
    #2;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    idle();
    a1 = 0; a2 = 0;
    reset = 1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    reset = 0;

    // Reset state at every address
    for (int a = 0; a < NREG; a++) begin
      a1 = AW'(a);
      a2 = AW'(NREG - 1 - a);
      probe();
      chk("reset_read", 32'(rd1), (a == 0) ? 32'hFF : 32'h0);
    end

    // Write with forwarding, then read back
    a1 = 2; we = 1; a3 = 2; wd = 8'hA5;
    probe();
    chk("forward_a5", 32'(rd1), 32'hA5);
    cycle();
    idle();
    probe();
    chk("stored_a5", 32'(rd1), 32'hA5);
    we = 1; a3 = 0; wd = 8'h33;
    cycle();
    idle();
    probe();
    chk("write_addr0_sp", 32'(sp), 32'hFF);

    // Scoreboard
    a2 = 3; iss = 1; idst = 3;
    cycle();
    idle();
    probe();
    chk("pending_set", 32'(p2), 32'h1);
    cycle();
    we = 1; a3 = 3; wd = 8'h5C;
    probe();
    chk("pending_write_resolves", 32'(p2), 32'h0);
    cycle();
    idle();
    iss = 1; idst = 3; we = 1; a3 = 3; wd = 8'h11;
    cycle();
    idle();
    probe();
    chk("pending_set_wins", 32'(p2), 32'h1);

    // Underflow then pushes
    op = 2'b10;
    cycle();
    idle();
    probe();
    chk("pop_empty_sp", 32'(sp), 32'hFF);
    chk("underflow_set", 32'(udf), 32'h1);
    op = 2'b01;
    cycle();
    probe();
    chk("push1", 32'(sp), 32'hFE);
    cycle();
    probe();
    chk("push2", 32'(sp), 32'hFD);
    cycle();
    idle();
    probe();
    chk("push3", 32'(sp), 32'hFC);
    chk("underflow_sticky", 32'(udf), 32'h1);

    // Load zero with push, then overflow
    swe = 1; swd = 8'h00; op = 2'b01;
    cycle();
    idle();
    probe();
    chk("load_zero_sp", 32'(sp), 32'h00);
    chk("load_no_overflow", 32'(ovf), 32'h0);
    op = 2'b01;
    cycle();
    idle();
    probe();
    chk("overflow_sp_held", 32'(sp), 32'h00);
    chk("overflow_set", 32'(ovf), 32'h1);

    // Reset discards concurrent write, issue and push
    reset = 1; we = 1; a3 = 1; wd = 8'h77; iss = 1; idst = 1; op = 2'b01; a1 = 1;
    cycle();
    idle();
    a2 = 0;
    probe();
    chk("reset_discard_write", 32'(rd1), 32'h00);
    chk("reset_discard_issue", 32'(p1), 32'h0);
    chk("reset_sp", 32'(rd2), 32'hFF);
    chk("reset_flags", {30'b0, ovf, udf}, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      we    = 1'($urandom);
      a3    = AW'($urandom);
      wd    = DW'($urandom);
      swe   = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: swd = 8'h00;
        1: swd = BASE;
        2: swd = 8'h02;
        default: swd = DW'($urandom);
      endcase
      op    = 2'($urandom);
      iss   = 1'($urandom);
      idst  = AW'($urandom);
      a1    = AW'($urandom);
      a2    = AW'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_scoreboard_register_file.md
# stack_scoreboard_register_file

Parametrised general-purpose register file for the gpp datapath. Register 0 is a dedicated stack pointer with hardware push/pop, registers 1..2^ADDRESS_WIDTH-1 are general registers, and a per-register pending scoreboard tracks in-flight writes. It provides two combinational read ports with same-cycle write-back forwarding, one write port and the processor id. It sits between the decode stage (reads, issue) and the write-back stage (writes).

## Interface
- ADDRESS_WIDTH, 2, register address width; register count is 2^ADDRESS_WIDTH
- DATA_WIDTH, 8, register and data width
- STACK_BASE, all ones, stack pointer reset value and empty-stack top; the stack grows downward
- PROCESSOR_ID, 0, constant driven on id, zero-extended/truncated to DATA_WIDTH
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- general_register_write_enable  in  1  write-back strobe
- address_3  in  ADDRESS_WIDTH  write address
- general_register_write_data  in  DATA_WIDTH  write data
- stack_write_enable  in  1  direct load of the stack pointer
- stack_register_write_data  in  DATA_WIDTH  stack pointer load value
- stack_operation  in  2  00 none, 01 push, 10 pop, 11 treated as none
- issue_enable  in  1  an instruction targeting issue_destination is issued
- issue_destination  in  ADDRESS_WIDTH  destination of the issued instruction
- address_1, address_2  in  ADDRESS_WIDTH  read addresses
- read_data_1, read_data_2  out  DATA_WIDTH  read data
- pending_1, pending_2  out  1  scoreboard bit of address_1 / address_2
- stack_pointer  out  DATA_WIDTH  current stack pointer
- stack_overflow, stack_underflow  out  1  sticky error flags
- id  out  DATA_WIDTH  PROCESSOR_ID

## Operation
- General write: on a clock edge with general_register_write_enable=1 and address_3≠0, register[address_3] <= general_register_write_data. Writes to address 0 are ignored.
- Read: read_data_n = register[address_n] for address_n≠0, and stack_pointer for address_n=0.
- Forwarding: if general_register_write_enable=1, address_3=address_n and address_n≠0, read_data_n = general_register_write_data in the same cycle.
- Stack pointer update, priority high to low:
  - reset: SP <= STACK_BASE.
  - stack_write_enable: SP <= stack_register_write_data.
  - push: if SP=0, SP is held and stack_overflow <= 1; otherwise SP <= SP-1.
  - pop: if SP=STACK_BASE, SP is held and stack_underflow <= 1; otherwise SP <= SP+1.
  - stack_operation is ignored in a cycle with stack_write_enable=1.
- Scoreboard: one pending bit per register 1..N-1; the bit for register 0 is constant 0.
  - issue_enable=1 with issue_destination≠0 sets pending[issue_destination].
  - A general write clears pending[address_3].
  - Issue and write to the same address in the same cycle: set wins, so the bit stays 1.
  - Issue to an already pending register leaves it at 1.
- pending_n = pending[address_n] AND NOT(general_register_write_enable AND address_3=address_n). A same-cycle write is thus seen as resolved, consistent with forwarding. A same-cycle issue is not visible until the next cycle.
- Flags are sticky and are cleared only by reset.

## Timing
- All state updates on the rising edge of clk. Reads, forwarding, pending_n and id are combinational, with zero cycles latency.
- Reset, sampled at an edge, sets: all general registers 0, SP=STACK_BASE, all pending bits 0, both flags 0. Every other input is ignored in that cycle.
- After reset, outputs read: read_data_n 0 (STACK_BASE for address 0), pending_n 0, stack_pointer STACK_BASE, flags 0, id PROCESSOR_ID.
- Reset asserted mid-operation discards any same-cycle write, issue or stack operation.
- Before the first reset edge, register contents are undefined.
- A new SP value is visible on stack_pointer and on address-0 reads one cycle after the push/pop/load edge. There is no SP forwarding.
- Back-to-back pushes or pops decrement or increment once per cycle.

## Test plan
- Reset, then read all addresses -> read_data 0 for addresses 1-3, 8'hFF for address 0; flags 0; pending 0.
- Write 8'hA5 to address 2 with address_1=2 in the same cycle -> read_data_1=8'hA5 before the edge and after it. Write to address 0 -> stack_pointer unchanged.
- Issue to address 3 -> pending_2=1 (address_2=3) the next cycle. Write address 3 in a later cycle -> pending_2=0 combinationally in that cycle. Issue and write address 3 in the same cycle -> pending stays 1.
- Pop at SP=8'hFF -> SP stays 8'hFF, stack_underflow=1 and stays 1. Three pushes -> SP 8'hFE, 8'hFD, 8'hFC on successive cycles.
- Load SP=8'h00 via stack_write_enable together with push -> SP=8'h00, no overflow. Push next cycle -> SP stays 8'h00, stack_overflow=1.
- Assert reset while a write, issue and push are requested -> all state returns to reset values, and the written register reads 0.
